rx_agc_ctrl: RTL

//  Receive AGC controller sitting directly downstream of the per-channel RSSI block.

---
 rtl/rx_agc_pkg.sv | 16 +
 rtl/agc_sat_counter.sv | 35 +++
 rtl/rx_agc_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rx_agc_pkg.sv
// rx_agc_pkg
//   Shared definitions for the receive AGC controller: the controller state
//   encoding and the gain step sizes used for clip back-off and normal
//   window tracking.
package rx_agc_pkg;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } agc_state_t;

  localparam int AGC_STEP_OVER = 2;
  localparam int AGC_STEP_NORM = 1;

endpackage

// File: rtl/agc_sat_counter.sv
// agc_sat_counter
//   Saturating up-counter with synchronous clear and terminal-count compare.
//   Used by the AGC controller for both the settle wait and the dwell count.
// Ports
//   clock     in  1      clock
//   reset     in  1      synchronous, active-high; clears the count
//   clear     in  1      synchronous clear (priority over inc)
//   inc       in  1      increment; holds at all-ones instead of wrapping
//   terminal  in  CNT_W  terminal value to compare against
//   at_term   out 1      count == terminal
module agc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_term
);

  logic [CNT_W-1:0] count;

  // Count register: clear wins, and the count sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = (count == terminal);

endmodule

// File: rtl/rx_agc_ctrl.sv
// rx_agc_ctrl
//   Receive AGC controller downstream of the per-channel RSSI block. Steps
//   the PGA gain code to hold rssi inside [thresh_lo, thresh_hi], backs off
//   by two steps on ADC clipping, waits for the rssi filter to settle after
//   every gain change, and reports lock and carrier presence.
// Ports
//   clock        in   1       sample clock
//   reset        in   1       synchronous, active-high
//   enable       in   1       0 holds the controller in its reset state
//   rssi         in   16      filtered |adc| magnitude
//   over_count   in   16      filtered clip rate
//   thresh_hi    in   16      upper rssi bound
//   thresh_lo    in   16      lower rssi bound
//   over_thresh  in   16      clip-rate limit
//   dwell        in   16      consecutive cycles needed to lock or unlock
//   gain         out  GAIN_W  PGA gain code
//   gain_strobe  out  1       one-cycle pulse with every gain change
//   locked       out  1       registered LOCKED indication
//   carrier      out  1       registered (rssi >= thresh_lo)
module rx_agc_ctrl
  import rx_agc_pkg::*;
#(
  parameter int GAIN_W        = 5,
  parameter int MAX_GAIN      = 20,
  parameter int SETTLE_CYCLES = 128,
  parameter int CNT_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       rssi,
  input  logic [15:0]       over_count,
  input  logic [15:0]       thresh_hi,
  input  logic [15:0]       thresh_lo,
  input  logic [15:0]       over_thresh,
  input  logic [15:0]       dwell,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_strobe,
  output logic              locked,
  output logic              carrier
);

  localparam logic [CNT_W-1:0]  SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [GAIN_W:0]   MAX_WIDE    = (GAIN_W+1)'(MAX_GAIN);
  localparam logic [GAIN_W:0]   STEP_OVER   = (GAIN_W+1)'(AGC_STEP_OVER);
  localparam logic [GAIN_W:0]   STEP_NORM   = (GAIN_W+1)'(AGC_STEP_NORM);

  agc_state_t        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d, gain_cand;
  logic              strobe_q, strobe_d;
  logic              locked_q;
  logic              carrier_q;

  logic              hold;
  logic              cond_over, cond_hi, cond_lo, cond_in;
  logic [CNT_W-1:0]  dwell_term;
  logic              settle_clr, settle_inc, settle_done;
  logic              dwell_clr, dwell_inc, dwell_done;
  logic [GAIN_W:0]   gain_ext, gain_dec_over, gain_dec_norm, gain_inc_norm;

  assign hold = reset || !enable;

  // Window conditions in priority order; only one of them is ever true.
  assign cond_over = (over_count > over_thresh);
  assign cond_hi   = !cond_over && (rssi > thresh_hi);
  assign cond_lo   = !cond_over && !cond_hi && (rssi < thresh_lo);
  assign cond_in   = !cond_over && !cond_hi && !cond_lo;

  // A dwell of zero behaves like a dwell of one.
  assign dwell_term = (dwell == 16'd0) ? '0 : CNT_W'(dwell - 16'd1);

  // One extra bit so a decrement below zero shows up in the top bit.
  assign gain_ext      = {1'b0, gain_q};
  assign gain_dec_over = gain_ext - STEP_OVER;
  assign gain_dec_norm = gain_ext - STEP_NORM;
  assign gain_inc_norm = gain_ext + STEP_NORM;

  // Clamped candidate gain for whichever out-of-window condition is active.
  always_comb begin
    gain_cand = gain_q;
    if (cond_over) begin
      gain_cand = gain_dec_over[GAIN_W] ? '0 : gain_dec_over[GAIN_W-1:0];
    end else if (cond_hi) begin
      gain_cand = gain_dec_norm[GAIN_W] ? '0 : gain_dec_norm[GAIN_W-1:0];
    end else if (cond_lo) begin
      gain_cand = (gain_inc_norm > MAX_WIDE) ? GAIN_W'(MAX_GAIN)
                                             : gain_inc_norm[GAIN_W-1:0];
    end
  end

  agc_sat_counter #(.CNT_W(CNT_W)) u_settle_cnt (
    .clock    (clock),
    .reset    (hold),
    .clear    (settle_clr),
    .inc      (settle_inc),
    .terminal (SETTLE_TERM),
    .at_term  (settle_done)
  );

  agc_sat_counter #(.CNT_W(CNT_W)) u_dwell_cnt (
    .clock    (clock),
    .reset    (hold),
    .clear    (dwell_clr),
    .inc      (dwell_inc),
    .terminal (dwell_term),
    .at_term  (dwell_done)
  );

  // Next-state logic. A gain change always restarts the settle wait; a
  // clamped step that changes nothing keeps measuring and restarts dwell.
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    strobe_d   = 1'b0;
    settle_clr = 1'b0;
    settle_inc = 1'b0;
    dwell_clr  = 1'b0;
    dwell_inc  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (settle_done) begin
          state_d    = MEASURE;
          settle_clr = 1'b1;
          dwell_clr  = 1'b1;
        end else begin
          settle_inc = 1'b1;
        end
      end
      MEASURE: begin
        if (!cond_in) begin
          dwell_clr = 1'b1;
          if (gain_cand != gain_q) begin
            gain_d     = gain_cand;
            strobe_d   = 1'b1;
            state_d    = SETTLE;
            settle_clr = 1'b1;
          end
        end else if (dwell_done) begin
          state_d   = LOCKED;
          dwell_clr = 1'b1;
        end else begin
          dwell_inc = 1'b1;
        end
      end
      LOCKED: begin
        if (cond_over) begin
          state_d   = MEASURE;
          dwell_clr = 1'b1;
        end else if (!cond_in) begin
          if (dwell_done) begin
            state_d   = MEASURE;
            dwell_clr = 1'b1;
          end else begin
            dwell_inc = 1'b1;
          end
        end else begin
          dwell_clr = 1'b1;
        end
      end
      default: begin
        state_d    = SETTLE;
        settle_clr = 1'b1;
        dwell_clr  = 1'b1;
      end
    endcase
  end

  // State and output registers. The reload to MAX_GAIN on hold is silent.
  always_ff @(posedge clock) begin
    if (hold) begin
      state_q   <= SETTLE;
      gain_q    <= GAIN_W'(MAX_GAIN);
      strobe_q  <= 1'b0;
      locked_q  <= 1'b0;
      carrier_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      strobe_q  <= strobe_d;
      locked_q  <= (state_q == LOCKED);
      carrier_q <= (rssi >= thresh_lo);
    end
  end

  assign gain        = gain_q;
  assign gain_strobe = strobe_q;
  assign locked      = locked_q;
  assign carrier     = carrier_q;

endmodule
